// File: rtl/serial_word_shifter_if.sv
// rtl/serial_word_shifter_if.sv - parallel word load handshake for serial_word_shifter
interface serial_word_shifter_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/serial_word_shifter.sv
// rtl/serial_word_shifter.sv - serializes a parallel word LSB-first behind a one-cycle frame clear
module serial_word_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                 t_clk,
    input  logic                 rn,
    serial_word_shifter_if.slave load,
    output logic                 i,
    output logic                 r,
    output logic                 bit_valid,
    output logic                 bit_last,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             at_last;
    logic             accept;

    assign at_last         = (state == SHIFT) && (cnt == LAST);
    assign load.load_ready = rn && ((state == IDLE) || at_last);
    assign accept          = load.load_valid && load.load_ready;

    // Outputs decode registered state only, so reset forces them immediately.
    assign i         = (state == SHIFT) && shreg[0];
    assign r         = (state != SHIFT);
    assign bit_valid = (state == SHIFT);
    assign bit_last  = at_last;
    assign busy      = (state != IDLE);

    always_ff @(posedge t_clk or negedge rn) begin
        if (!rn) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        case (state)
            IDLE: state_nxt = IDLE;
            CLR:  state_nxt = SHIFT;
            SHIFT: begin
                shreg_nxt = shreg >> 1;
                cnt_nxt   = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A load overrides the final shift so back-to-back frames keep one clear cycle.
        if (accept) begin
            state_nxt = CLR;
            shreg_nxt = load.load_data;
            cnt_nxt   = '0;
        end
    end
endmodule

// File: doc/serial_word_shifter.md
Name: serial_word_shifter

Overview:
Upstream feeder for the bit-serial two's-complement stage. Accepts a parallel word through a valid/ready handshake, pulses the stage's frame clear, then shifts the word out LSB-first, one bit per t_clk, on the stage's serial input. It produces the `i` and `r` signals the complementer consumes, plus framing strobes for the downstream collector.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.

Ports:
t_clk  input  1  rising-edge clock, shared with the complementer stage
rn  input  1  asynchronous, active-low reset
load_valid  input  1  load_data is valid this cycle
load_ready  output  1  block can accept a word this cycle
load_data  input  WIDTH  word to serialize; bit 0 is sent first
i  output  1  serial data bit to the complementer
r  output  1  active-high frame clear to the complementer
bit_valid  output  1  `i` carries a live data bit this cycle
bit_last  output  1  current bit is bit WIDTH-1 of the frame
busy  output  1  a frame is in progress (state CLR or SHIFT)

Behaviour:
- Clock is t_clk. Reset rn is asynchronous and active-low. All state updates on the rising edge of t_clk.
- Internal registers:
  - state: IDLE, CLR or SHIFT.
  - shreg: WIDTH bits.
  - cnt: clog2(WIDTH) bits.
- Reset (rn=0), effective immediately regardless of clock:
  - state=IDLE, shreg=0, cnt=0.
  - Outputs: i=0, r=1, bit_valid=0, bit_last=0, busy=0, load_ready=0 while rn=0.
- load_ready = rn & (state==IDLE | (state==SHIFT & cnt==WIDTH-1)).
- Accept = load_valid & load_ready at a rising edge. On accept: shreg <= load_data, cnt <= 0, state <= CLR.
- load_data is ignored when no accept occurs.
- IDLE:
  - r=1, i=0, bit_valid=0, busy=0.
  - Stays in IDLE until accept.
- CLR (exactly one cycle):
  - r=1, i=0, bit_valid=0, busy=1.
  - Next state is always SHIFT.
- SHIFT:
  - r=0, i=shreg[0], bit_valid=1, busy=1.
  - bit_last = (cnt==WIDTH-1).
  - Each edge: shreg <= shreg>>1 (zero fill), cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: accept → CLR (new frame, back-to-back); otherwise → IDLE, cnt<=0.
- Latency: accept at edge N gives CLR in cycle N+1, bit k in cycle N+2+k, and bit_last in cycle N+WIDTH+1.
- Minimum frame period is WIDTH+1 cycles. Every frame is preceded by at least one r=1 cycle, so the complementer's internal state is always cleared before bit 0.
- No backpressure: once started, a frame cannot stall. Downstream must sample on bit_valid.
- Outputs i, r, bit_valid, bit_last and busy are decoded from registers only; no input-to-output combinational path except via load_ready.
- rn asserted mid-frame:
  - Frame is abandoned; outputs go to reset values asynchronously.
  - After rn deasserts, the block is in IDLE with load_ready=1; no partial frame resumes.
- load_valid held high while not ready: no effect; the word is accepted at the first ready edge.
- cnt never exceeds WIDTH-1; no wrap-around in SHIFT beyond the last bit.

Test Plan:
- Reset check: hold rn=0 for 3 cycles, toggling load_valid → i=0, r=1, bit_valid=0, busy=0, load_ready=0. Release rn → load_ready=1 on the next cycle.
- Single frame (WIDTH=8), load_data=8'h06 accepted at edge N:
  - Cycle N+1: r=1.
  - Cycles N+2..N+9: i = 0,1,1,0,0,0,0,0 with bit_valid=1, bit_last only at N+9.
  - Then IDLE.
  - With the complementer attached, the collected y bits equal 8'hFA.
- Back-to-back: load_valid held high with 8'h01 then 8'h80 → second accept at the bit_last edge; one CLR cycle (r=1) between frames; i streams 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1; total 18 cycles.
- Not-ready: present 8'hFF during SHIFT (cnt<7) → load_ready=0; no accept until the bit_last cycle; the first frame's bits are unchanged.
- Reset mid-frame: pull rn low at bit 3 of 8'hA5 → r=1 and bit_valid=0 immediately. Release rn, load 8'h3C → clean full frame 0,0,1,1,1,1,0,0.
- Boundary WIDTH=2: load 2'b10 → CLR, then i=0 (bit_last=0), then i=1 (bit_last=1); back-to-back frame period of 3 cycles verified.
